// File: rtl/demux_pkg.sv
// Shared definitions for the serial-to-parallel bit demultiplexer:
// the FILL/HOLD state encoding and the default word width.
package demux_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Binary position select to one-hot bit mask of WIDTH bits.
module onehot_dec #(
  parameter  int WIDTH = 16,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/demux16_deser.sv
// Routes serial bits into a WIDTH-bit word, either by an auto-incrementing
// pointer or by explicit select, and hands the word off once every position is written.
module demux16_deser
  import demux_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel_mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] ptr
);

  state_t           state;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] hot;
  logic [WIDTH-1:0] mask_nxt;
  logic [SEL_W-1:0] idx;
  logic             accept;

  assign idx      = sel_mode ? sel : ptr;
  assign accept   = in_valid && in_ready;
  assign mask_nxt = mask | hot;

  onehot_dec #(.WIDTH(WIDTH)) u_dec (
    .sel    (idx),
    .onehot (hot)
  );

  // Handshake flags are pure decodes of the state register, so they stay glitch-free.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
      out   <= '0;
      mask  <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        FILL: begin
          // Flush wins over a bit presented in the same cycle.
          if (flush) begin
            out  <= '0;
            mask <= '0;
            ptr  <= '0;
          end else if (accept) begin
            out  <= (out & ~hot) | (in_bit ? hot : '0);
            mask <= mask_nxt;
            if (!sel_mode) ptr <= ptr + SEL_W'(1);
            if (&mask_nxt) state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= FILL;
            out   <= '0;
            mask  <= '0;
            ptr   <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_demux16_deser.sv
// Bench for demux16_deser: a vector table plus hand-built multi-cycle sequences,
// expectations queued at drive time and popped after each clock edge.
module tb_demux16_deser;

  logic        clk;
  logic        rst_n;
  logic        in_bit;
  logic        in_valid;
  logic        in_ready;
  logic        sel_mode;
  logic [3:0]  sel;
  logic        flush;
  logic [15:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ptr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] out;
    logic        ov;
    logic        ir;
    logic [3:0]  ptr;
  } exp_t;

  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic        in_bit;
    logic        sel_mode;
    logic [3:0]  sel;
    logic        flush;
    logic        out_ready;
    logic [15:0] e_out;
    logic        e_ov;
    logic        e_ir;
    logic [3:0]  e_ptr;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];

  demux16_deser #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel_mode  (sel_mode),
    .sel       (sel),
    .flush     (flush),
    .out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ptr       (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input string nm, input logic r, input logic v, input logic b,
                      input logic m, input logic [3:0] s, input logic f, input logic o,
                      input logic [15:0] eo, input logic eov, input logic eir,
                      input logic [3:0] ep);
    exp_t e;
    rst_n     = r;
    in_valid  = v;
    in_bit    = b;
    sel_mode  = m;
    sel       = s;
    flush     = f;
    out_ready = o;
    sb.push_back('{name: nm, out: eo, ov: eov, ir: eir, ptr: ep});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty actual=0 required=1", nm);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".out"}, dout, e.out);
      chk({e.name, ".out_valid"}, {15'd0, out_valid}, {15'd0, e.ov});
      chk({e.name, ".in_ready"}, {15'd0, in_ready}, {15'd0, e.ir});
      chk({e.name, ".ptr"}, {12'd0, ptr}, {12'd0, e.ptr});
    end
  endtask

  initial begin
    logic [15:0] pat;
    logic [15:0] acc;
    logic [15:0] pat2;

    rst_n = 0; in_valid = 0; in_bit = 0; sel_mode = 0; sel = 0; flush = 0; out_ready = 0;

    //           rst v  b  m  sel   f  o   out       ov  ir  ptr
    tbl[0] = '{1'b0, 0, 0, 0, 4'd0, 0, 0, 16'h0000, 0, 1, 4'd0};
    tbl[1] = '{1'b1, 1, 1, 0, 4'd0, 0, 0, 16'h0001, 0, 1, 4'd1};
    tbl[2] = '{1'b1, 0, 1, 0, 4'd0, 0, 0, 16'h0001, 0, 1, 4'd1};
    tbl[3] = '{1'b1, 1, 1, 0, 4'd0, 0, 0, 16'h0003, 0, 1, 4'd2};
    tbl[4] = '{1'b1, 1, 1, 1, 4'd9, 0, 0, 16'h0203, 0, 1, 4'd2};
    tbl[5] = '{1'b1, 0, 0, 0, 4'd0, 0, 1, 16'h0203, 0, 1, 4'd2};
    tbl[6] = '{1'b1, 1, 0, 1, 4'd0, 0, 0, 16'h0202, 0, 1, 4'd2};
    tbl[7] = '{1'b1, 1, 1, 0, 4'd0, 1, 0, 16'h0000, 0, 1, 4'd0};
    tbl[8] = '{1'b1, 1, 1, 0, 4'd0, 0, 0, 16'h0001, 0, 1, 4'd1};
    tbl[9] = '{1'b0, 1, 1, 0, 4'd0, 0, 0, 16'h0000, 0, 1, 4'd0};

    for (int i = 0; i < 10; i++)
      step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].in_valid, tbl[i].in_bit,
           tbl[i].sel_mode, tbl[i].sel, tbl[i].flush, tbl[i].out_ready,
           tbl[i].e_out, tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_ptr);

    // Auto fill: bits 1,0,1,1,0...0,1 land LSB first -> 16'h800D.
    pat = 16'h800D;
    acc = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      acc[i] = pat[i];
      if (i < 15)
        step($sformatf("auto%0d", i), 1, 1, pat[i], 0, 4'd0, 0, 0, acc, 0, 1, 4'(i + 1));
      else
        step("auto_done", 1, 1, pat[i], 0, 4'd0, 0, 0, 16'h800D, 1, 0, 4'd0);
    end

    // Back-pressure: held word ignores inputs, including flush and select.
    for (int i = 0; i < 5; i++)
      step($sformatf("hold%0d", i), 1, 1, 1'(i), 1'(i), 4'(i), 1'(i), 0, 16'h800D, 1, 0, 4'd0);
    step("release", 1, 1, 1, 0, 4'd0, 0, 1, 16'h0000, 0, 1, 4'd0);

    // Explicit fill: sel 15..0, ones only at 3 and 12; ptr stays 0.
    acc = 16'h0000;
    for (int s = 15; s >= 0; s--) begin
      logic b;
      b = (s == 3) || (s == 12);
      acc[s] = b;
      if (s > 0)
        step($sformatf("expl%0d", s), 1, 1, b, 1, 4'(s), 0, 0, acc, 0, 1, 4'd0);
      else
        step("expl_done", 1, 1, b, 1, 4'(s), 0, 0, 16'h1008, 1, 0, 4'd0);
    end
    step("expl_release", 1, 0, 0, 0, 4'd0, 0, 1, 16'h0000, 0, 1, 4'd0);

    // Duplicate writes: sel 5 twice, completion only on the 16th distinct position.
    step("dup_a", 1, 1, 1, 1, 4'd5, 0, 0, 16'h0020, 0, 1, 4'd0);
    step("dup_b", 1, 1, 0, 1, 4'd5, 0, 0, 16'h0000, 0, 1, 4'd0);
    begin
      int n;
      n = 0;
      for (int s = 0; s < 16; s++) begin
        if (s != 5) begin
          n++;
          step($sformatf("dup_s%0d", s), 1, 1, 0, 1, 4'(s), 0, 0, 16'h0000,
               (n == 15), (n != 15), 4'd0);
        end
      end
    end
    step("dup_release", 1, 0, 0, 0, 4'd0, 0, 1, 16'h0000, 0, 1, 4'd0);

    // Flush after 7 auto bits; the bit presented with flush is dropped.
    acc = 16'h0000;
    for (int i = 0; i < 7; i++) begin
      acc[i] = 1'b1;
      step($sformatf("pre%0d", i), 1, 1, 1, 0, 4'd0, 0, 0, acc, 0, 1, 4'(i + 1));
    end
    step("flush", 1, 1, 1, 0, 4'd0, 1, 0, 16'h0000, 0, 1, 4'd0);
    pat2 = 16'hA5C3;
    acc  = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      acc[i] = pat2[i];
      if (i < 15)
        step($sformatf("post%0d", i), 1, 1, pat2[i], 0, 4'd0, 0, 0, acc, 0, 1, 4'(i + 1));
      else
        step("post_done", 1, 1, pat2[i], 0, 4'd0, 0, 0, 16'hA5C3, 1, 0, 4'd0);
    end

    // Reset while holding a word, then first cycle after release.
    step("rst_hold", 0, 1, 1, 0, 4'd0, 0, 0, 16'h0000, 0, 1, 4'd0);
    step("rst_after", 1, 0, 0, 0, 4'd0, 0, 0, 16'h0000, 0, 1, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux16_deser.md
DEMUX16_DESER -- requirements
Module: demux16_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of output bit positions; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have derived localparam SEL_W = log2(WIDTH), default 4, giving the width of the position select.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port in_bit  input  1  serial data bit to be routed.
REQ-006 The block SHALL have port in_valid  input  1  in_bit is presented.
REQ-007 The block SHALL have port in_ready  output  1  the block accepts in_bit this cycle.
REQ-008 The block SHALL have port sel_mode  input  1  0 = auto pointer addressing, 1 = explicit sel addressing.
REQ-009 The block SHALL have port sel  input  SEL_W  target bit position when sel_mode=1.
REQ-010 The block SHALL have port flush  input  1  discard the partially built word.
REQ-011 The block SHALL have port out  output  WIDTH  assembled word register.
REQ-012 The block SHALL have port out_valid  output  1  out holds a complete word.
REQ-013 The block SHALL have port out_ready  input  1  the consumer takes out.
REQ-014 The block SHALL have port ptr  output  SEL_W  current auto pointer.

Function
REQ-015 The block SHALL implement a two-state machine, FILL and HOLD, entered in FILL after reset.
REQ-016 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 A bit SHALL be accepted only when in_valid and in_ready are both 1 in the same cycle.
REQ-018 An accepted bit SHALL be written to position idx = (sel_mode ? sel : ptr) of out and SHALL set bit idx of an internal WIDTH-bit written mask.
REQ-019 ptr SHALL increment by 1 modulo WIDTH on each accepted bit with sel_mode=0 and SHALL be unchanged by accepted bits with sel_mode=1.
REQ-020 A repeated write to an already-written position SHALL overwrite that bit and SHALL leave the mask unchanged.
REQ-021 When an accepted bit leaves the mask all ones, the state SHALL be HOLD in the next cycle, giving out_valid one cycle after the completing bit is accepted.
REQ-022 In HOLD, out SHALL be stable, and in_valid, sel, sel_mode and flush SHALL be ignored.
REQ-023 In HOLD with out_ready=1, the next cycle SHALL be FILL with out, mask and ptr all cleared to 0.
REQ-024 In FILL with flush=1, the next cycle SHALL have out, mask and ptr cleared to 0, any bit presented in the same cycle SHALL be dropped, and the state SHALL remain FILL.
REQ-025 Mode SHALL be switchable between accepted bits mid-word; the mask SHALL decide completion regardless of mode mix.
REQ-026 out_ready while in FILL SHALL have no effect.

Reset
REQ-027 With rst_n=0 at a clock edge, the block SHALL set state=FILL, out=0, mask=0, ptr=0, out_valid=0 and in_ready=1 from the next cycle, overriding all other inputs including an in-progress HOLD.
REQ-028 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-029 The state encoding (FILL=0, HOLD=1) and the default WIDTH SHALL be placed in the shared package demux_pkg.
REQ-030 No sub-module SHALL be required; the position decode (SEL_W to one-hot WIDTH) MAY be a sub-module named onehot_dec.

Verification
REQ-031 The bench SHALL cover auto fill: sel_mode=0, 16 accepted bits 1,0,1,1,0,0,0,0,0,0,0,0,0,0,0,1 -> out=16'h800D, out_valid=1 exactly one cycle after the 16th bit is accepted.
REQ-032 The bench SHALL cover explicit fill: sel_mode=1, sel=15 down to 0, in_bit=1 only at sel=3 and sel=12 -> out=16'h1008, ptr=0 throughout.
REQ-033 The bench SHALL cover back-pressure: HOLD with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out unchanged; out_ready=1 -> FILL, out=0 next cycle.
REQ-034 The bench SHALL cover duplicate writes: sel_mode=1, sel=5 written with 1 then 0, remaining 15 positions written 0 -> out=16'h0000, completion on the 16th distinct position, not on the 16th write.
REQ-035 The bench SHALL cover flush: 7 auto bits then flush=1 with in_valid=1 -> ptr=0, out=0, bit dropped; a following 16 bits complete normally.
REQ-036 The bench SHALL cover reset in HOLD: rst_n=0 for one cycle -> out_valid=0, in_ready=1, out=0, ptr=0.
